// File: rtl/and_check_pkg.sv
// Shared definitions for the AND-gate checker: FSM states, stimulus vector order
// and the expected truth table of the gate under test.
package and_check_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int unsigned NUM_VEC = 4;

   // {A,B} per index, index 0 in the low bits: 00, 10, 11, 01
   localparam logic [7:0] VEC_TABLE = {2'b01, 2'b11, 2'b10, 2'b00};

   // Expected gate output indexed by {A,B}: AND
   localparam logic [3:0] EXP_FN = 4'b1000;

   function automatic logic [1:0] vec_at(input logic [1:0] idx);
      return VEC_TABLE[{idx, 1'b0} +: 2];
   endfunction

   function automatic logic expected(input logic [1:0] ab);
      return EXP_FN[ab];
   endfunction

endpackage

// File: rtl/and_check_dwell_cnt.sv
// Dwell counter: counts enabled cycles from zero and flags the cycle on which
// the count reaches DWELL_CYCLES-1.
module and_check_dwell_cnt #(
   parameter int unsigned DWELL_CYCLES = 100
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic tc
);

   localparam logic [15:0] LAST = 16'(DWELL_CYCLES - 1);

   logic [15:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (enable)
         cnt <= cnt + 16'd1;
   end

   assign tc = enable && !clear && (cnt == LAST);

endmodule

// File: rtl/and_gate_checker.sv
// Drives the four {A,B} vectors into a 2-input gate, samples its output after a
// dwell and counts mismatches against AND. Optional macro: AND_CHECK_FAIL_CAPTURE_EN.
module and_gate_checker
   import and_check_pkg::*;
#(
   parameter int unsigned DWELL_CYCLES = 100,
   parameter int unsigned ERR_W        = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             dut_out,
   output logic             stim_a,
   output logic             stim_b,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic [1:0]       fail_vec
);

   localparam logic [ERR_W-1:0] ERR_MAX = '1;

   state_t           state, state_nxt;
   logic [1:0]       idx, idx_nxt;
   logic [1:0]       stim_nxt;
   logic [ERR_W-1:0] err_nxt;
   logic             done_nxt, pass_nxt;
   logic             accept, mismatch, tc;

   and_check_dwell_cnt #(.DWELL_CYCLES(DWELL_CYCLES)) u_dwell (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (state != DRIVE),
      .enable (state == DRIVE),
      .tc     (tc)
   );

   assign busy     = (state == DRIVE) || (state == SAMPLE);
   assign accept   = start && ((state == IDLE) || (state == DONE));
   assign mismatch = (state == SAMPLE) && (dut_out != expected({stim_a, stim_b}));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         idx     <= '0;
         stim_a  <= 1'b0;
         stim_b  <= 1'b0;
         err_cnt <= '0;
         done    <= 1'b0;
         pass    <= 1'b0;
      end else begin
         state   <= state_nxt;
         idx     <= idx_nxt;
         stim_a  <= stim_nxt[1];
         stim_b  <= stim_nxt[0];
         err_cnt <= err_nxt;
         done    <= done_nxt;
         pass    <= pass_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      stim_nxt  = {stim_a, stim_b};
      err_nxt   = err_cnt;
      done_nxt  = done;
      pass_nxt  = pass;
      unique case (state)
         IDLE, DONE: begin
            if (accept) begin
               state_nxt = DRIVE;
               idx_nxt   = '0;
               stim_nxt  = vec_at(2'd0);
               err_nxt   = '0;
               done_nxt  = 1'b0;
               pass_nxt  = 1'b0;
            end
         end
         DRIVE: begin
            if (tc)
               state_nxt = SAMPLE;
         end
         SAMPLE: begin
            if (mismatch && (err_cnt != ERR_MAX))
               err_nxt = err_cnt + 1'b1;
            if (idx != 2'(NUM_VEC - 1)) begin
               state_nxt = DRIVE;
               idx_nxt   = idx + 2'd1;
               stim_nxt  = vec_at(idx + 2'd1);
            end else begin
               // pass uses err_nxt so the final vector's mismatch is counted
               state_nxt = DONE;
               stim_nxt  = 2'b00;
               done_nxt  = 1'b1;
               pass_nxt  = (err_nxt == '0);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef AND_CHECK_FAIL_CAPTURE_EN
   logic [1:0] fail_q;

   // err_cnt only grows within a sequence, so zero marks the first mismatch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         fail_q <= '0;
      else if (accept)
         fail_q <= '0;
      else if (mismatch && (err_cnt == '0))
         fail_q <= {stim_a, stim_b};
   end

   assign fail_vec = fail_q;
`else
   assign fail_vec = 2'b00;
`endif

endmodule
